// File: rtl/alu_op_selector_pkg.sv
// ALU front-panel selector: shared types and constants.
// Used by the selector, the ALU and the LED status stage.
package alu_op_selector_pkg;

  localparam int SEL_W        = 3;
  localparam int DEF_OP_COUNT = 8;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_PENDING = 2'd1,
    ST_COMMIT  = 2'd2
  } state_e;

  typedef enum logic [SEL_W-1:0] {
    OPC_ADD = 3'd0,
    OPC_SUB = 3'd1,
    OPC_AND = 3'd2,
    OPC_OR  = 3'd3,
    OPC_XOR = 3'd4,
    OPC_SHL = 3'd5,
    OPC_SHR = 3'd6,
    OPC_CMP = 3'd7
  } alu_opc_e;

  function automatic logic [SEL_W-1:0] sel_step(
    input logic [SEL_W-1:0] s,
    input logic             up,
    input int               n
  );
    logic [SEL_W-1:0] m;
    m = SEL_W'(n - 1);
    return up ? ((s + 1'b1) & m) : ((s - 1'b1) & m);
  endfunction

endpackage

// File: rtl/alu_op_selector_debounce.sv
// Button conditioner: 2-FF sync, stability counter, rising edge.
// PRESS is one cycle wide on each accepted 0->1 debounced level.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic PRESS
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic          s1_q;
  logic          s2_q;
  logic          deb_q;
  logic          deb_d;
  logic          prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // accept the synced level only after a full run of differing cycles
  always_comb begin
    deb_d = deb_q;
    cnt_d = cnt_q;
    if (s2_q == deb_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_MAX) begin
      deb_d = s2_q;
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // sync chain, debounce state and edge-detect history
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1_q   <= 1'b0;
      s2_q   <= 1'b0;
      deb_q  <= 1'b0;
      cnt_q  <= '0;
      prev_q <= 1'b0;
    end else begin
      s1_q   <= BTN;
      s2_q   <= s1_q;
      deb_q  <= deb_d;
      cnt_q  <= cnt_d;
      prev_q <= deb_q;
    end
  end

  assign PRESS = deb_q & ~prev_q;

endmodule

// File: rtl/alu_op_selector.sv
// ALU opcode selector: stage with NEXT/PREV, commit with OK.
// CAMBIO flags a staged opcode that has not been committed yet.
module alu_op_selector
  import alu_op_selector_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int OP_COUNT        = DEF_OP_COUNT
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic             BTN_NEXT,
  input  logic             BTN_PREV,
  input  logic             BTN_OK,
  output logic [SEL_W-1:0] SEL,
  output logic [SEL_W-1:0] OP,
  output logic             CAMBIO,
  output logic             OP_VALID
);

  logic p_next;
  logic p_prev;
  logic p_ok;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
    .CLK   (CLK),
    .RST_N (RST_N),
    .BTN   (BTN_NEXT),
    .PRESS (p_next)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_prev (
    .CLK   (CLK),
    .RST_N (RST_N),
    .BTN   (BTN_PREV),
    .PRESS (p_prev)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ok (
    .CLK   (CLK),
    .RST_N (RST_N),
    .BTN   (BTN_OK),
    .PRESS (p_ok)
  );

  state_e           state_q;
  state_e           state_d;
  logic [SEL_W-1:0] sel_q;
  logic [SEL_W-1:0] sel_d;
  logic [SEL_W-1:0] op_q;
  logic [SEL_W-1:0] op_d;
  logic             cambio_q;
  logic             step;

  // a step needs exactly one of NEXT/PREV; both together cancel
  assign step = p_next ^ p_prev;

  // next state, staged and committed opcodes
  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    op_d    = op_q;
    unique case (state_q)
      ST_IDLE: begin
        if (step) begin
          sel_d   = sel_step(sel_q, p_next, OP_COUNT);
          state_d = ST_PENDING;
        end
      end
      ST_PENDING: begin
        if (p_ok) begin
          op_d    = sel_q;
          state_d = ST_COMMIT;
        end else if (step) begin
          sel_d   = sel_step(sel_q, p_next, OP_COUNT);
          state_d = (sel_d == op_q) ? ST_IDLE : ST_PENDING;
        end
      end
      ST_COMMIT: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // state, opcode and change-pending registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q  <= ST_IDLE;
      sel_q    <= '0;
      op_q     <= '0;
      cambio_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      sel_q    <= sel_d;
      op_q     <= op_d;
      cambio_q <= (state_d == ST_PENDING);
    end
  end

  assign SEL      = sel_q;
  assign OP       = op_q;
  assign CAMBIO   = cambio_q;
  assign OP_VALID = (state_q == ST_COMMIT);

endmodule

// File: tb/tb_alu_op_selector.sv
// Bench for alu_op_selector: directed cases plus random buttons.
// A behavioural model is compared against the DUT every cycle.
module tb_alu_op_selector;

  localparam int D   = 4;
  localparam int OPC = 8;

  logic       clk    = 1'b0;
  logic       rst_n  = 1'b0;
  logic       b_next = 1'b0;
  logic       b_prev = 1'b0;
  logic       b_ok   = 1'b0;
  logic [2:0] sel;
  logic [2:0] op;
  logic       cambio;
  logic       op_valid;

  int n_cmp  = 0;
  int n_bad  = 0;
  int ov_cnt = 0;
  bit chk_en = 0;

  always #5 clk = ~clk;

  alu_op_selector #(
    .DEBOUNCE_CYCLES (D),
    .OP_COUNT        (OPC)
  ) dut (
    .CLK      (clk),
    .RST_N    (rst_n),
    .BTN_NEXT (b_next),
    .BTN_PREV (b_prev),
    .BTN_OK   (b_ok),
    .SEL      (sel),
    .OP       (op),
    .CAMBIO   (cambio),
    .OP_VALID (op_valid)
  );

  bit hq[3][$];
  bit m_deb[3];
  bit m_prs[3];
  int m_sel;
  int m_op;
  bit m_commit;

  task automatic chk(string nm, int act, int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d want %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int b = 0; b < 3; b++) begin
      hq[b].delete();
      for (int i = 0; i < D + 2; i++) hq[b].push_front(1'b0);
      m_deb[b] = 1'b0;
      m_prs[b] = 1'b0;
    end
    m_sel    = 0;
    m_op     = 0;
    m_commit = 0;
  endtask

  function automatic bit rawb(int b);
    case (b)
      0:       return b_next;
      1:       return b_prev;
      default: return b_ok;
    endcase
  endfunction

  // behavioural model: raw history window + abstract selector
  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) begin
        m_reset();
      end else begin
        if (m_commit) begin
          m_commit = 0;
        end else if (m_prs[2] && m_sel != m_op) begin
          m_op     = m_sel;
          m_commit = 1;
        end else if (m_prs[0] != m_prs[1]) begin
          if (m_prs[0]) m_sel = (m_sel + 1) % OPC;
          else          m_sel = (m_sel + OPC - 1) % OPC;
        end
        for (int b = 0; b < 3; b++) begin
          bit all_diff;
          hq[b].push_front(rawb(b));
          void'(hq[b].pop_back());
          all_diff = 1;
          for (int i = 2; i <= D + 1; i++)
            if (hq[b][i] == m_deb[b]) all_diff = 0;
          m_prs[b] = 0;
          if (all_diff) begin
            m_deb[b] = !m_deb[b];
            m_prs[b] = m_deb[b];
          end
        end
      end
    end
  end

  // per-cycle comparison of all outputs against the model
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && chk_en) begin
        chk("sel", int'(sel), m_sel);
        chk("op", int'(op), m_op);
        chk("cambio", int'(cambio), int'(m_sel != m_op && !m_commit));
        chk("op_valid", int'(op_valid), int'(m_commit));
        if (op_valid) ov_cnt++;
      end
    end
  end

  task automatic cyc(int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic setb(int b, bit v);
    case (b)
      0:       b_next = v;
      1:       b_prev = v;
      default: b_ok   = v;
    endcase
  endtask

  task automatic press(int b, int hold);
    setb(b, 1'b1);
    cyc(hold);
    setb(b, 1'b0);
    cyc(10);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    cyc(2);
    rst_n = 1'b1;
    cyc(1);
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  initial begin
    int start;
    int lat;
    cyc(3);
    rst_n  = 1'b1;
    chk_en = 1;
    at_neg();
    chk("rst_sel", int'(sel), 0);
    chk("rst_op", int'(op), 0);
    chk("rst_cambio", int'(cambio), 0);
    chk("rst_op_valid", int'(op_valid), 0);
    cyc(1);

    // async reset mid-PENDING
    repeat (3) press(0, 8);
    chk("t1_sel_before", int'(sel), 3);
    @(posedge clk);
    #4;
    rst_n = 1'b0;
    #1;
    chk("t1_async_sel", int'(sel), 0);
    chk("t1_async_op", int'(op), 0);
    chk("t1_async_cambio", int'(cambio), 0);
    chk("t1_model_sel", m_sel, 0);
    cyc(2);
    rst_n = 1'b1;
    cyc(2);

    // stage three and commit
    repeat (3) press(0, 8);
    chk("t2_sel", int'(sel), 3);
    chk("t2_model_sel", m_sel, 3);
    chk("t2_cambio", int'(cambio), 1);
    chk("t2_op", int'(op), 0);
    ov_cnt = 0;
    press(2, 8);
    chk("t2_op_commit", int'(op), 3);
    chk("t2_model_op", m_op, 3);
    chk("t2_ov_pulses", ov_cnt, 1);
    chk("t2_cambio_after", int'(cambio), 0);

    // wrap both directions
    do_reset();
    press(1, 8);
    chk("t3_wrap_prev", int'(sel), 7);
    chk("t3_cambio", int'(cambio), 1);
    press(0, 8);
    chk("t3_wrap_next", int'(sel), 0);
    chk("t3_cambio_back", int'(cambio), 0);

    // bouncing input must not step
    for (int i = 0; i < 10; i++) begin
      b_next = 1'b1;
      cyc(3);
      b_next = 1'b0;
      cyc(2);
    end
    cyc(10);
    chk("t4_bounce_sel", int'(sel), 0);
    press(0, 8);
    chk("t4_one_step", int'(sel), 1);

    // simultaneous presses
    b_next = 1'b1;
    b_prev = 1'b1;
    cyc(8);
    b_next = 1'b0;
    b_prev = 1'b0;
    cyc(10);
    chk("t5_next_prev", int'(sel), 1);
    press(0, 8);
    chk("t5_sel2", int'(sel), 2);
    ov_cnt = 0;
    b_ok   = 1'b1;
    b_next = 1'b1;
    cyc(8);
    b_ok   = 1'b0;
    b_next = 1'b0;
    cyc(10);
    chk("t5_ok_wins_op", int'(op), 2);
    chk("t5_ok_wins_sel", int'(sel), 2);
    chk("t5_ov_pulses", ov_cnt, 1);

    // OK in IDLE, long hold and latency
    ov_cnt = 0;
    press(2, 8);
    chk("t6_ok_idle_ov", ov_cnt, 0);
    chk("t6_ok_idle_op", int'(op), 2);
    start  = int'(sel);
    lat    = 0;
    b_next = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      @(posedge clk);
      #1;
      if (lat == 0 && int'(sel) != start) lat = k;
    end
    chk("t6_latency_edges_from_raw", lat, 2 + D + 1);
    cyc(80);
    b_next = 1'b0;
    cyc(10);
    chk("t6_hold_one_step", int'(sel), 3);

    // random button activity against the model
    for (int it = 0; it < 400; it++) begin
      if ($urandom_range(0, 99) == 0) do_reset();
      b_next = ($urandom_range(0, 3) == 0);
      b_prev = ($urandom_range(0, 3) == 0);
      b_ok   = ($urandom_range(0, 3) == 0);
      cyc($urandom_range(1, 12));
    end
    b_next = 1'b0;
    b_prev = 1'b0;
    b_ok   = 1'b0;
    cyc(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
